// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32-bit divider (DIV/DIVU) for the EX stage.
// Define DIV_SIGNED_EN to honour signed_div (abs capture + sign fixup).
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stallreq_for_ex
);

  typedef enum logic [1:0] {
    FREE,
    DIVZERO,
    ON,
    END
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_nx;
  logic [31:0] dvd_nx;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        go;
  logic        abort;

  assign go    = start & ~annul;
  assign abort = annul | ~start;

  assign stallreq_for_ex = start & ~ready & ~annul;

  // One restoring step: trial remainder minus divisor, keep if no borrow
  assign trial  = {rem, dvd[31]};
  assign diff   = trial - {1'b0, dvs};
  assign qbit   = ~diff[32];
  assign rem_nx = qbit ? diff[31:0] : trial[31:0];
  assign dvd_nx = {dvd[30:0], qbit};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign abs1  = (signed_div & opdata1[31]) ? -opdata1 : opdata1;
  assign abs2  = (signed_div & opdata2[31]) ? -opdata2 : opdata2;
  assign q_fix = neg_q ? -dvd_nx : dvd_nx;
  assign r_fix = neg_r ? -rem_nx : rem_nx;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div;
  assign abs1  = opdata1;
  assign abs2  = opdata2;
  assign q_fix = dvd_nx;
  assign r_fix = rem_nx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FREE: begin
        if (go) begin
          state_nx = (opdata2 == 32'd0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        state_nx = abort ? FREE : END;
      end
      ON: begin
        if (abort) begin
          state_nx = FREE;
        end else if (cnt == 6'd31) begin
          state_nx = END;
        end
      end
      END: begin
        state_nx = FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      result <= '0;
      ready  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      unique case (state)
        FREE: begin
          if (go) begin
            cnt <= '0;
            rem <= '0;
            dvd <= abs1;
            dvs <= abs2;
`ifdef DIV_SIGNED_EN
            neg_q <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_r <= signed_div & opdata1[31];
`endif
          end
        end
        DIVZERO: begin
          if (!abort) begin
            result <= '0;
            ready  <= 1'b1;
          end
        end
        ON: begin
          if (!abort) begin
            rem <= rem_nx;
            dvd <= dvd_nx;
            cnt <= cnt + 6'd1;
            // Final iteration: fixed-up result lands together with END
            if (cnt == 6'd31) begin
              result <= {r_fix, q_fix};
              ready  <= 1'b1;
            end
          end
        end
        END: begin
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the EX stage of the five-stage pipeline, executing DIV and DIVU. It computes quotient and remainder by radix-2 restoring division, one bit per cycle. While a division is in flight it raises `stallreq_for_ex` toward the pipeline controller, which freezes the front of the pipeline. The 64-bit result goes to the HI/LO write path.

## Interface
Parameters:
- none; the width is fixed at 32 bits and the iteration count at 32.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low; asserts immediately, releases synchronously to `clk`
- `start`  in  1  EX holds a DIV/DIVU instruction; level, held until `ready`
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU
- `opdata1`  in  32  dividend, captured at start
- `opdata2`  in  32  divisor, captured at start
- `annul`  in  1  cancel the in-flight division (exception flush)
- `result`  out  64  {remainder[31:0], quotient[31:0]} → {HI, LO}
- `ready`  out  1  result valid; registered; high for exactly one cycle
- `stallreq_for_ex`  out  1  combinational; equals `start & ~ready & ~annul`

## Operation
- States: FREE, DIVZERO, ON, END. The iteration counter `cnt` is 6 bits wide.
- FREE:
  - If `start & ~annul`: capture the operands.
  - If `opdata2 == 0`, go to DIVZERO.
  - Otherwise go to ON, with `cnt` = 0, the working remainder = 0, and the working dividend = |opdata1|. The divisor is stored as |opdata2|.
  - The absolute value is taken only when `signed_div` = 1. Otherwise the operand is used raw.
- ON: each cycle does one iteration.
  - Shift {rem, dvd} left by 1.
  - If rem ≥ dvs: rem −= dvs and shift in quotient bit 1. Otherwise shift in 0.
  - `cnt` += 1. When the iteration with `cnt` = 31 completes, go to END.
- END:
  - Sign fixup, only when signed: the quotient is negated if sign(op1) ^ sign(op2). The remainder takes the sign of the dividend.
  - `result` is written and `ready` = 1.
  - Unconditional transition to FREE on the next edge.
- DIVZERO: `result` = 64'h0, then go to END. No exception is raised.
- Abort: `annul` = 1, or `start` = 0, while in ON or DIVZERO sends the block to FREE on the next edge. No `ready` is produced and `result` is unchanged.
- `result` holds its last value until the next completed division.
- Overflow: 0x80000000 / −1 (signed) gives quotient 0x80000000 and remainder 0. This falls out naturally from the unsigned absolute value and the wrap-around negate.
- Reset values: state = FREE, `cnt` = 0, `result` = 0, `ready` = 0, all working registers = 0. `stallreq_for_ex` then follows `start`.

## Timing
- Cycle 0: `start` is sampled in FREE and `stallreq_for_ex` = 1.
- Cycles 1–32: ON. Cycle 33: END, with `ready` = 1, `stallreq_for_ex` = 0, and `result` valid.
- Normal latency: 33 cycles from start to `ready`, and 33 stall cycles.
- Divide-by-zero: DIVZERO at cycle 1, END at cycle 2. `ready` is high at cycle 2.
- Back-to-back: the END→FREE edge admits a new `start` at the following cycle. There is no bubble beyond END.
- `annul` and `start` arriving together in FREE: the operation is not started.
- `annul` at the same edge as entry to END cannot happen, because END is reached only from ON or DIVZERO at the edge. `annul` during END is ignored: `ready` still pulses, but `stallreq_for_ex` is 0.
- Reset mid-operation: immediate return to FREE with all outputs zero. No `ready`.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: `signed_div` is honoured, with absolute-value capture and sign fixup as above.
  - Undefined: `signed_div` is ignored. Every division is unsigned, the absolute-value and negate logic is not built, and DIV behaves as DIVU.

## Test plan
- Unsigned divide: `opdata1` = 100, `opdata2` = 7, `signed_div` = 0, `start` held.
  - `stallreq_for_ex` = 1 for cycles 0–32.
  - Cycle 33: `ready` = 1, `result` = {32'd2, 32'd14}.
- Signed divide, with `DIV_SIGNED_EN` defined: −7 / 2.
  - `result` = {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - Without the macro, the same operands give quotient 32'h7FFFFFFC and remainder 32'h00000001.
- Divide by zero: 5 / 0.
  - `ready` at cycle 2, `result` = 64'h0.
  - Stall lasts 2 cycles, and the following division starts normally.
- Annul: assert `annul` at cycle 10 of 100/7.
  - `stallreq_for_ex` = 0 that cycle. FREE at cycle 11.
  - No `ready` pulse, and `result` keeps its prior value.
- Reset mid-operation: drive `rst` low at cycle 15.
  - State FREE, `result` = 0, `ready` = 0 immediately, before the next clock edge.
  - After release, 9/3 gives `result` = {0, 3}.
- Overflow: 0x80000000 / 0xFFFFFFFF, signed.
  - `result` = {32'h0, 32'h80000000} at cycle 33.
